// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared multiply-accumulate walks TAPS taps per accepted sample,
// driving a circular sample RAM and a coefficient ROM (both 1-cycle synchronous reads).
module fir_mac_sequencer #(
    parameter int TAPS  = 16,
    parameter int AW    = 4,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int SHIFT = 15,
    parameter int ACCW  = DW + CW + AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_sample,
    output logic          buf_we,
    output logic [AW-1:0] buf_waddr,
    output logic [DW-1:0] buf_wdata,
    output logic [AW-1:0] buf_raddr,
    input  logic [DW-1:0] buf_rdata,
    output logic [AW-1:0] coef_addr,
    input  logic [CW-1:0] coef_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_sample,
    output logic          busy
);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WRITE,
        MAC,
        DRAIN,
        OUT
    } state_t;

    localparam logic [AW-1:0]          LAST    = AW'(TAPS - 1);
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-(2 ** (DW - 1)));

    state_t state_q, state_d;

    logic [AW-1:0]          wptr_q, wptr_d;
    logic [AW-1:0]          cnt_q, cnt_d;
    logic [DW-1:0]          sample_q, sample_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic                   rdValid_q, rdValid_d;
    logic [DW-1:0]          outSample_q, outSample_d;

    logic signed [DW+CW-1:0] product;
    logic signed [ACCW-1:0]  productExt;
    logic signed [ACCW-1:0]  shifted;
    logic [DW-1:0]           satValue;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (cnt_q == LAST) state_d = IDLE;
            IDLE:    if (in_valid) state_d = WRITE;
            WRITE:   state_d = MAC;
            MAC:     if (cnt_q == LAST) state_d = DRAIN;
            DRAIN:   state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    // Full-precision product, sign-extended into the accumulator before summing.
    assign product    = $signed(buf_rdata) * $signed(coef_data);
    assign productExt = ACCW'(product);
    assign shifted    = acc_d >>> SHIFT;

    always_comb begin
        if (shifted > SAT_MAX) begin
            satValue = {1'b0, {(DW-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            satValue = {1'b1, {(DW-1){1'b0}}};
        end else begin
            satValue = shifted[DW-1:0];
        end
    end

    // rdValid_q marks the cycle in which RAM/ROM data for the previous MAC issue is present.
    always_comb begin
        wptr_d      = wptr_q;
        cnt_d       = cnt_q;
        sample_d    = sample_q;
        acc_d       = acc_q;
        rdValid_d   = (state_q == MAC);
        outSample_d = outSample_q;
        case (state_q)
            INIT:  cnt_d = cnt_q + AW'(1);
            IDLE:  if (in_valid) sample_d = in_sample;
            WRITE: cnt_d = '0;
            MAC:   cnt_d = cnt_q + AW'(1);
            OUT:   if (out_ready) wptr_d = wptr_q + AW'(1);
            default: ;
        endcase
        if (state_q == WRITE) begin
            acc_d = '0;
        end else if (rdValid_q) begin
            acc_d = acc_q + productExt;
        end
        if (state_q == DRAIN) begin
            outSample_d = satValue;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            cnt_q       <= '0;
            sample_q    <= '0;
            acc_q       <= '0;
            rdValid_q   <= 1'b0;
            outSample_q <= '0;
        end else begin
            wptr_q      <= wptr_d;
            cnt_q       <= cnt_d;
            sample_q    <= sample_d;
            acc_q       <= acc_d;
            rdValid_q   <= rdValid_d;
            outSample_q <= outSample_d;
        end
    end

    // Outputs are gated by the reset level so everything reads zero while reset is held.
    always_comb begin
        in_ready   = 1'b0;
        buf_we     = 1'b0;
        buf_waddr  = '0;
        buf_wdata  = '0;
        buf_raddr  = '0;
        coef_addr  = '0;
        out_valid  = 1'b0;
        out_sample = '0;
        busy       = 1'b0;
        if (rst) begin
            out_sample = outSample_q;
            busy       = (state_q != IDLE);
            case (state_q)
                INIT: begin
                    buf_we    = 1'b1;
                    buf_waddr = cnt_q;
                end
                IDLE: in_ready = 1'b1;
                WRITE: begin
                    buf_we    = 1'b1;
                    buf_waddr = wptr_q;
                    buf_wdata = sample_q;
                end
                MAC: begin
                    buf_raddr = wptr_q - cnt_q;
                    coef_addr = cnt_q;
                end
                OUT: out_valid = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
